fifo_rd_ctrl: RTL
=================

# fifo_rd_ctrl

Read-side controller of the asynchronous FIFO, the consumer of the write-domain gray pointer. It synchronizes the foreign write pointer into the read clock domain and decodes it to binary. It owns the local read pointer, in both binary and gray form, and generates RAM read enables, the empty flag, an occupancy count and a sticky overflow error. Its gray read pointer output is the value the write domain synchronizes back.

## Interface
Parameters:
- ADDR_WIDTH, 4, FIFO RAM address width; depth = 2**ADDR_WIDTH; pointer width PW = ADDR_WIDTH+1
- SYNC_STAGES, 2, flop stages in the write-pointer synchronizer; legal range 2..4

Ports:
- clk  in  1  read-domain clock; single clock for the whole block
- rst  in  1  reset, synchronous, active-high
- wptr_g_async  in  PW  gray write pointer from the write domain, asynchronous to clk
- rd_req  in  1  consumer requests one word this cycle
- rd_en  out  1  RAM read strobe, = rd_req & ~empty (combinational)
- rd_addr  out  ADDR_WIDTH  RAM read address, = rptr_b[ADDR_WIDTH-1:0]
- rptr_g  out  PW  registered gray read pointer, sent to the write domain
- empty  out  1  registered empty flag
- rd_count  out  PW  registered occupancy, 0..2**ADDR_WIDTH
- ovf_err  out  1  sticky overflow error

## Operation
- The synchronizer is a SYNC_STAGES-deep flop chain on wptr_g_async. All stages reset to 0. The last stage is wptr_g_s.
- wptr_b_s = gray-to-binary(wptr_g_s), computed combinationally, PW bits.
- Read pointer state is rptr_b (binary, PW bits) and rptr_g (gray), both registered.
- rptr_b_next = rptr_b + rd_en, modulo 2**PW. It wraps from 2**PW-1 to 0.
- rptr_g_next = bin-to-gray(rptr_b_next). rptr_g is always exactly one register behind rptr_b_next, with no extra pipeline stage.
- empty is registered as (bin-to-gray(rptr_b_next) == wptr_g_s).
- rd_count is registered as (wptr_b_s - rptr_b_next) mod 2**PW.
- ovf_err sets when the computed count exceeds 2**ADDR_WIDTH. It stays set until rst.
- rd_req while empty=1:
  - rd_en=0.
  - The pointer holds.
  - The request is dropped with no error.
- Occupancy changes in the same cycle:
  - A simultaneous read and a new synchronized write pointer value are both reflected in the next empty and rd_count.
  - A read that empties the FIFO is followed by empty=1 on the next edge.
- Reset:
  - rst overrides everything, including mid-operation.
  - On the next edge rptr_b=0, rptr_g=0, empty=1, rd_count=0, ovf_err=0, and the synchronizer is cleared.
  - rd_en is forced to 0 while rst=1.

## Timing
- Write-pointer visibility latency: SYNC_STAGES edges from a stable wptr_g_async to wptr_g_s, plus 1 edge to empty and rd_count. That is 3 edges with the default.
- Read latency:
  - rd_en asserts in the same cycle as rd_req.
  - rd_addr is valid in that cycle.
  - RAM data timing belongs to the RAM.
- rptr_g updates 1 edge after each rd_en, with exactly one bit changing per increment.
- Back-to-back reads are sustained at 1 per cycle while empty=0.
- Reset values of all outputs:
  - rd_en=0
  - rd_addr=0
  - rptr_g=0
  - empty=1
  - rd_count=0
  - ovf_err=0

## Structure
- Shared package fifo_pkg holds:
  - bin2gray and gray2bin as automatic functions, parameterised by width via the caller
  - the pointer-width helper: PW = ADDR_WIDTH+1
  - the synchronizer depth default
- The natural sub-module is ptr_sync: a parameterised SYNC_STAGES x PW flop chain with synchronous reset. The write-side controller reuses it for rptr_g.
- Everything else is inline in fifo_rd_ctrl: pointer registers, flag and count logic.

## Test plan
Defaults are ADDR_WIDTH=2 and SYNC_STAGES=2, so depth is 4 and PW is 3.
- Reset: hold rst for 2 edges with wptr_g_async=3'b011 → empty=1, rd_count=0, rptr_g=000, ovf_err=0. After release, empty=0 and rd_count=2 exactly 3 edges later.
- Fill and drain: drive wptr_g_async through 001, 011, 010, 110 (4 writes), then rd_req=1 for 6 cycles → rd_en high for exactly 4 cycles, rd_addr 0,1,2,3, and rptr_g 001,011,010,110. empty=1 after the 4th read. rd_count steps 4,3,2,1,0.
- Wrap-around: perform 8 write/read pairs → rptr_b wraps 7→0 and rptr_g returns to 000. empty is correct at every step and rd_count never exceeds 1.
- Simultaneous events: rd_count=1, then a read and a new write pointer arrive in the same cycle → rd_count stays 1 and empty stays 0.
- Overflow: with rptr=0, jump wptr_g_async to gray(5)=111 → ovf_err=1 after 3 edges. It stays 1 after the pointer returns to a legal value and clears only on rst.
- Reset mid-operation: assert rst during a stream of reads with rd_count=3 → next edge gives rptr_g=000, empty=1, rd_count=0. rd_en=0 during rst.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: gray/binary conversion and pointer sizing.
// Combinational only; callers zero-extend into FUNC_W and truncate the result to their own width.
package fifo_pkg;

  localparam int FUNC_W          = 32;
  localparam int SYNC_STAGES_DEF = 2;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [FUNC_W-1:0] bin2gray(input logic [FUNC_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Zero upper bits of a zero-extended gray value decode to zero, so truncation is safe.
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b[FUNC_W-1] = g[FUNC_W-1];
    for (int i = FUNC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ptr_sync.sv
// STAGES-deep flop chain that brings a foreign gray pointer into the local clock domain.
// Latency STAGES edges; no backpressure, samples every cycle; synchronous active-high reset clears all stages.
module ptr_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side async FIFO controller: syncs the write gray pointer, owns the read pointer, flags and count.
// rd_en same-cycle as rd_req; write visibility SYNC_STAGES+1 edges; requests while empty are dropped silently.
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH:0]   wptr_g_async,
  input  logic                  rd_req,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [ADDR_WIDTH:0]   rptr_g,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   rd_count,
  output logic                  ovf_err
);

  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PW-1:0] r_rptr_b;
  logic [PW-1:0] r_rptr_g;
  logic          r_empty;
  logic [PW-1:0] r_rd_count;
  logic          r_ovf_err;

  logic [PW-1:0] w_wptr_g_s;
  logic [PW-1:0] w_wptr_b_s;
  logic [PW-1:0] w_rptr_b_next;
  logic [PW-1:0] w_rptr_g_next;
  logic [PW-1:0] w_count_next;
  logic          w_rd_en;

  ptr_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_wptr_sync (
    .clk (clk),
    .rst (rst),
    .i_d (wptr_g_async),
    .o_q (w_wptr_g_s)
  );

  assign w_wptr_b_s    = PW'(gray2bin(FUNC_W'(w_wptr_g_s)));
  assign w_rd_en       = rd_req & ~r_empty & ~rst;
  assign w_rptr_b_next = r_rptr_b + PW'(w_rd_en);
  assign w_rptr_g_next = PW'(bin2gray(FUNC_W'(w_rptr_b_next)));
  // Count uses the post-read pointer so a same-cycle read and write arrival cancel out.
  assign w_count_next  = w_wptr_b_s - w_rptr_b_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr_b   <= '0;
      r_rptr_g   <= '0;
      r_empty    <= 1'b1;
      r_rd_count <= '0;
      r_ovf_err  <= 1'b0;
    end else begin
      r_rptr_b   <= w_rptr_b_next;
      r_rptr_g   <= w_rptr_g_next;
      r_empty    <= (w_rptr_g_next == w_wptr_g_s);
      r_rd_count <= w_count_next;
      if (w_count_next > PW'(DEPTH)) begin
        r_ovf_err <= 1'b1;
      end
    end
  end

  assign rd_en    = w_rd_en;
  assign rd_addr  = r_rptr_b[ADDR_WIDTH-1:0];
  assign rptr_g   = r_rptr_g;
  assign empty    = r_empty;
  assign rd_count = r_rd_count;
  assign ovf_err  = r_ovf_err;

endmodule
